// File: rtl/qam_demap_pkg.sv
// Shared constants and slicing/mapping helpers for the M-QAM demapper.
// Pure functions only; no state.
package qam_demap_pkg;

  localparam int K_DFLT = 2;
  localparam int L      = 1 << K_DFLT;
  localparam int BPS    = 2 * K_DFLT;

  typedef struct packed {
    logic        clip;
    logic [15:0] idx;
  } slice_t;

  // Nearest odd-integer level: idx = (x + L) >>> 1, clamped to [0, L-1]; ties go up.
  function automatic slice_t slice_idx(input int x, input int k = K_DFLT);
    int     l;
    int     raw;
    slice_t s;
    l      = 1 << k;
    raw    = (x + l) >>> 1;
    s.clip = 1'b0;
    s.idx  = 16'(raw);
    if (raw < 0) begin
      s.clip = 1'b1;
      s.idx  = '0;
    end else if (raw > l - 1) begin
      s.clip = 1'b1;
      s.idx  = 16'(l - 1);
    end
    return s;
  endfunction

  function automatic logic [15:0] to_gray(input logic [15:0] idx);
    return idx ^ (idx >> 1);
  endfunction

endpackage

// File: rtl/qam_demap_packer_slicer.sv
// Combinational single-axis slicer: level index plus clip flag.
// Zero latency; no flow control.
module qam_axis_slicer
  import qam_demap_pkg::*;
#(
  parameter int K    = 2,
  parameter int IN_W = 4
) (
  input  logic signed [IN_W-1:0] i_x,
  output logic        [K-1:0]    o_idx,
  output logic                   o_clip
);

  slice_t w_s;

  assign w_s    = slice_idx(int'(i_x), K);
  assign o_idx  = K'(w_s.idx);
  assign o_clip = w_s.clip;

endmodule

// File: rtl/qam_demap_packer.sv
// M-QAM demapper and symbol packer; closing symbol gives out_valid two cycles after acceptance.
// Input stalls only when a word-closing symbol meets an un-taken output word.
module qam_demap_packer
  import qam_demap_pkg::*;
#(
  parameter int K            = 2,
  parameter int IN_W         = 4,
  parameter int SYM_PER_WORD = 2,
  parameter int GRAY         = 0
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic signed [IN_W-1:0]                  in_i,
  input  logic signed [IN_W-1:0]                  in_q,
  input  logic                                    in_last,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [2*K*SYM_PER_WORD-1:0]             out_data,
  output logic [$clog2(SYM_PER_WORD+1)-1:0]       out_count,
  output logic                                    out_last,
  output logic [15:0]                             clip_cnt
);

  localparam int SYM_W = 2 * K;
  localparam int OUT_W = SYM_W * SYM_PER_WORD;
  localparam int CNT_W = $clog2(SYM_PER_WORD + 1);

  logic [K-1:0]     w_i_idx, w_q_idx;
  logic             w_i_clip, w_q_clip;
  logic [K-1:0]     w_i_bits, w_q_bits;
  logic [SYM_W-1:0] w_sym;
  logic             w_in_hs;

  logic             r_s1_vld;
  logic [SYM_W-1:0] r_s1_sym;
  logic             r_s1_last;
  logic [OUT_W-1:0] r_acc;
  logic [CNT_W-1:0] r_n;
  logic             r_out_vld;
  logic [OUT_W-1:0] r_out_dat;
  logic [CNT_W-1:0] r_out_cnt;
  logic             r_out_last;
  logic [15:0]      r_clip_cnt;

  logic [CNT_W-1:0] w_n_inc;
  logic             w_close;
  logic             w_s1_adv;
  logic [OUT_W-1:0] w_merged;

  qam_axis_slicer #(.K(K), .IN_W(IN_W)) u_slice_i (
    .i_x    (in_i),
    .o_idx  (w_i_idx),
    .o_clip (w_i_clip)
  );

  qam_axis_slicer #(.K(K), .IN_W(IN_W)) u_slice_q (
    .i_x    (in_q),
    .o_idx  (w_q_idx),
    .o_clip (w_q_clip)
  );

  always_comb begin
    w_i_bits = w_i_idx;
    w_q_bits = w_q_idx;
    if (GRAY != 0) begin
      w_i_bits = K'(to_gray(16'(w_i_idx)));
      w_q_bits = K'(to_gray(16'(w_q_idx)));
    end
  end

  assign w_sym   = {w_i_bits, w_q_bits};
  assign w_n_inc = r_n + CNT_W'(1);
  assign w_close = r_s1_last || (w_n_inc == CNT_W'(SYM_PER_WORD));
  // Only a word-closing symbol needs the output register, so only it can be blocked.
  assign w_s1_adv = r_s1_vld && !(r_out_vld && !out_ready && w_close);
  assign in_ready = !r_s1_vld || w_s1_adv;
  assign w_in_hs  = in_valid && in_ready;

  // New symbol lands directly below the ones already accumulated, MSB first.
  assign w_merged = r_acc | ((OUT_W'(r_s1_sym) << (OUT_W - SYM_W)) >> (SYM_W * int'(r_n)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_vld   <= 1'b0;
      r_s1_sym   <= '0;
      r_s1_last  <= 1'b0;
      r_clip_cnt <= '0;
    end else begin
      if (w_in_hs) begin
        r_s1_vld  <= 1'b1;
        r_s1_sym  <= w_sym;
        r_s1_last <= in_last;
        if ((w_i_clip || w_q_clip) && (r_clip_cnt != 16'hFFFF))
          r_clip_cnt <= r_clip_cnt + 16'd1;
      end else if (w_s1_adv) begin
        r_s1_vld <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc      <= '0;
      r_n        <= '0;
      r_out_vld  <= 1'b0;
      r_out_dat  <= '0;
      r_out_cnt  <= '0;
      r_out_last <= 1'b0;
    end else if (w_s1_adv && w_close) begin
      r_out_vld  <= 1'b1;
      r_out_dat  <= w_merged;
      r_out_cnt  <= w_n_inc;
      r_out_last <= r_s1_last;
      r_acc      <= '0;
      r_n        <= '0;
    end else begin
      if (out_ready)
        r_out_vld <= 1'b0;
      if (w_s1_adv) begin
        r_acc <= w_merged;
        r_n   <= w_n_inc;
      end
    end
  end

  assign out_valid = r_out_vld;
  assign out_data  = r_out_dat;
  assign out_count = r_out_cnt;
  assign out_last  = r_out_last;
  assign clip_cnt  = r_clip_cnt;

endmodule

// File: tb/tb_qam_demap_packer.sv
// Directed bench for qam_demap_packer: natural-binary instance plus a Gray instance on shared inputs.
module tb_qam_demap_packer;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic signed [3:0] in_i, in_q;
  logic              in_last;
  logic              out_ready;

  logic              in_ready,  g_in_ready;
  logic              out_valid, g_out_valid;
  logic [7:0]        out_data,  g_out_data;
  logic [1:0]        out_count, g_out_count;
  logic              out_last,  g_out_last;
  logic [15:0]       clip_cnt,  g_clip_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  qam_demap_packer #(.K(2), .IN_W(4), .SYM_PER_WORD(2), .GRAY(0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_i(in_i), .in_q(in_q), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_count(out_count), .out_last(out_last), .clip_cnt(clip_cnt)
  );

  qam_demap_packer #(.K(2), .IN_W(4), .SYM_PER_WORD(2), .GRAY(1)) dut_g (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(g_in_ready),
    .in_i(in_i), .in_q(in_q), .in_last(in_last),
    .out_valid(g_out_valid), .out_ready(out_ready), .out_data(g_out_data),
    .out_count(g_out_count), .out_last(g_out_last), .clip_cnt(g_clip_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the accepting clock.
  task automatic send(input int xi, input int xq, input logic last);
    bit ok;
    ok       = 1'b0;
    in_valid = 1'b1;
    in_i     = 4'(xi);
    in_q     = 4'(xq);
    in_last  = last;
    for (int k = 0; k < 50 && !ok; k++) begin
      #1;
      if (in_ready === 1'b1) ok = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $error("FAIL send_timeout observed=stalled expected=accepted");
    end
  endtask

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_i      = '0;
    in_q      = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    #2 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_data",  32'(out_data),  32'h0);
    chk("rst_out_count", 32'(out_count), 32'h0);
    chk("rst_out_last",  32'(out_last),  32'h0);
    chk("rst_clip_cnt",  32'(clip_cnt),  32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 32'h1);

    // Basic word with N+2 latency
    send(-3, -3, 1'b0);
    send(3, 1, 1'b0);
    chk("basic_early_valid", 32'(out_valid), 32'h0);
    @(negedge clk);
    chk("basic_valid", 32'(out_valid), 32'h1);
    chk("basic_data",  32'(out_data),  32'h0E);
    chk("basic_count", 32'(out_count), 32'h2);
    chk("basic_last",  32'(out_last),  32'h0);
    chk("basic_clip",  32'(clip_cnt),  32'h0);
    @(negedge clk);
    chk("basic_taken", 32'(out_valid), 32'h0);

    // Gray mapping
    send(3, 1, 1'b0);
    send(-1, -1, 1'b0);
    @(negedge clk);
    chk("gray_valid", 32'(g_out_valid), 32'h1);
    chk("gray_data",  32'(g_out_data),  32'hB5);
    chk("bin_data_same_syms", 32'(out_data), 32'hE5);
    @(negedge clk);

    // Tie rounds up, out-of-range clips
    send(0, -2, 1'b0);
    send(-8, 7, 1'b0);
    @(negedge clk);
    chk("tieclip_data", 32'(out_data),   32'h93);
    chk("tieclip_gray", 32'(g_out_data), 32'hD2);
    chk("tieclip_clip", 32'(clip_cnt),   32'h1);
    @(negedge clk);

    // Flush of a partial word, then a fresh word from the MSBs
    send(1, 3, 1'b1);
    @(negedge clk);
    chk("flush_data",  32'(out_data),  32'hB0);
    chk("flush_count", 32'(out_count), 32'h1);
    chk("flush_last",  32'(out_last),  32'h1);
    send(-3, -3, 1'b0);
    send(3, 1, 1'b0);
    @(negedge clk);
    chk("after_flush_data", 32'(out_data), 32'h0E);
    chk("after_flush_last", 32'(out_last), 32'h0);
    @(negedge clk);

    // Back-to-back last symbols each form their own word
    send(1, 3, 1'b1);
    send(-1, -1, 1'b1);
    chk("lastlast_w1_data",  32'(out_data),  32'hB0);
    chk("lastlast_w1_count", 32'(out_count), 32'h1);
    @(negedge clk);
    chk("lastlast_w2_data",  32'(out_data),  32'h50);
    chk("lastlast_w2_last",  32'(out_last),  32'h1);
    @(negedge clk);

    // Backpressure
    out_ready = 1'b0;
    send(-3, -1, 1'b0);
    send(-3,  1, 1'b0);
    send(-3,  3, 1'b0);
    send(-1, -3, 1'b0);
    in_valid = 1'b1;
    in_i     = 4'(-1);
    in_q     = 4'(-1);
    in_last  = 1'b0;
    #1;
    chk("bp_stall_ready", 32'(in_ready),  32'h0);
    chk("bp_w1_valid",    32'(out_valid), 32'h1);
    chk("bp_w1_data",     32'(out_data),  32'h12);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("bp_hold_ready", 32'(in_ready), 32'h0);
    chk("bp_hold_data",  32'(out_data), 32'h12);
    out_ready = 1'b1;
    #1;
    chk("bp_pulse_ready", 32'(in_ready), 32'h1);
    @(negedge clk);
    out_ready = 1'b0;
    in_i      = 4'(-1);
    in_q      = 4'(1);
    #1;
    chk("bp_w2_valid", 32'(out_valid), 32'h1);
    chk("bp_w2_data",  32'(out_data),  32'h34);
    chk("bp_absorb_ready", 32'(in_ready), 32'h1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("bp_stall2_ready", 32'(in_ready), 32'h0);
    chk("bp_w2_hold",      32'(out_data), 32'h34);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_w3_data",  32'(out_data),  32'h56);
    chk("bp_w3_count", 32'(out_count), 32'h2);
    @(negedge clk);
    chk("bp_drained", 32'(out_valid), 32'h0);

    // Reset with a partial word pending
    send(3, 3, 1'b0);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'h0);
    chk("mid_rst_data",  32'(out_data),  32'h0);
    chk("mid_rst_count", 32'(out_count), 32'h0);
    chk("mid_rst_clip",  32'(clip_cnt),  32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send(-3, -3, 1'b0);
    send(-3, -1, 1'b0);
    @(negedge clk);
    chk("clean_valid", 32'(out_valid), 32'h1);
    chk("clean_data",  32'(out_data),  32'h01);
    chk("clean_count", 32'(out_count), 32'h2);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
